// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state, the
// priority-encoded hazard cause and the register-source match helper.
package ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [2:0] {
      H_NONE = 3'd0,
      H_MEM  = 3'd1,
      H_BR   = 3'd2,
      H_LU   = 3'd3,
      H_IM   = 3'd4
   } hazard_t;

   // x0 is hard-wired zero, so a load targeting it can never feed a consumer
   function automatic logic src_hit(logic used, logic [4:0] rs, logic [4:0] rd);
      return used && (rs == rd) && (rd != REG_ZERO);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side handshake bundle: decode/execute/memory status in, stage
// advance/hold/flush controls out.
interface pipe_hazard_ctrl_if;

   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] exe_rd_addr;
   logic       exe_DM_read;
   logic       exe_branch_taken;
   logic       dm_req;
   logic       dm_ready;
   logic       im_ready;

   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idexe_flush;
   logic       pipe_hold;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             exe_rd_addr, exe_DM_read, exe_branch_taken,
             dm_req, dm_ready, im_ready,
      input  pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
             exe_rd_addr, exe_DM_read, exe_branch_taken,
             dm_req, dm_ready, im_ready,
      output pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold
   );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_perf_cnt.sv
// Saturating event counter with asynchronous active-low clear; sticks at
// all-ones instead of wrapping.
module hazard_perf_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: picks advance/hold/flush for PC, IF/ID and
// ID/EXE each cycle and tracks stall/flush statistics plus a memory watchdog.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | pipe flowing; hazards resolved combinationally each cycle
//   MEM_WAIT | previous cycle froze on data memory; released as soon as
//            | dm_ready (or dm_req low) removes the wait, same cycle
module pipe_hazard_ctrl
   import ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_hazard_ctrl_if.slave    bus,
   output logic                 mem_timeout,
   output logic [CNT_WIDTH-1:0] lu_stall_cnt,
   output logic [CNT_WIDTH-1:0] mem_stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(MEM_TIMEOUT);

   state_t              state_q, state_d;
   logic [TO_WIDTH-1:0] wd_q, wd_d;
   logic                mem_timeout_q, mem_timeout_d;

   logic    mw;
   logic    lu;
   hazard_t cause;
   logic    pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold;

   always_comb begin
      mw = bus.dm_req & ~bus.dm_ready;
      lu = bus.exe_DM_read &
           (src_hit(bus.id_rs1_used, bus.id_rs1_addr, bus.exe_rd_addr) |
            src_hit(bus.id_rs2_used, bus.id_rs2_addr, bus.exe_rd_addr));

      if (mw)                        cause = H_MEM;
      else if (bus.exe_branch_taken) cause = H_BR;
      else if (lu)                   cause = H_LU;
      else if (!bus.im_ready)        cause = H_IM;
      else                           cause = H_NONE;
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idexe_flush = 1'b0;
      pipe_hold   = 1'b0;

      case (cause)
         H_MEM: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
         end
         H_BR: begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
         end
         H_LU: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idexe_flush = 1'b1;
         end
         H_IM: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
         end
         default: ;
      endcase

      // Reset drives a bubble into both front registers without waiting for a clock
      if (!rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idexe_flush = 1'b1;
         pipe_hold   = 1'b0;
      end
   end

   always_comb begin
      state_d       = mw ? MEM_WAIT : RUN;
      wd_d          = '0;
      mem_timeout_d = mem_timeout_q;

      // wd_q holds the index of the current MEM_WAIT cycle
      if (mw) begin
         if (state_q == RUN) begin
            wd_d = TO_WIDTH'(1);
         end else if (wd_q != TO_LIMIT) begin
            wd_d = wd_q + TO_WIDTH'(1);
         end else begin
            wd_d = wd_q;
         end
         if (wd_d == TO_LIMIT) begin
            mem_timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         wd_q          <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wd_q          <= wd_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   hazard_perf_cnt #(.WIDTH(CNT_WIDTH)) u_lu_cnt (
      .clk   (clk),
      .clr_n (rst),
      .inc   (cause == H_LU),
      .cnt   (lu_stall_cnt)
   );

   hazard_perf_cnt #(.WIDTH(CNT_WIDTH)) u_mem_cnt (
      .clk   (clk),
      .clr_n (rst),
      .inc   (cause == H_MEM),
      .cnt   (mem_stall_cnt)
   );

   hazard_perf_cnt #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .clr_n (rst),
      .inc   (cause == H_BR),
      .cnt   (flush_cnt)
   );

   assign bus.pc_write    = pc_write;
   assign bus.ifid_write  = ifid_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idexe_flush = idexe_flush;
   assign bus.pipe_hold   = pipe_hold;
   assign mem_timeout     = mem_timeout_q;

endmodule
